// File: rtl/uart_rx_ext_if.sv
// Receive-side handshake bundle for uart_rx_ext: payload, valid/ack and status flags.
interface uart_rx_ext_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ack;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 brk;

    modport master (
        output data, valid, parity_err, frame_err, overrun, brk,
        input  ack
    );

    modport slave (
        input  data, valid, parity_err, frame_err, overrun, brk,
        output ack
    );
endinterface

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver with 3-sample majority voting and a valid/ack output handshake.
// Define UART_RX_BREAK_EN to detect break frames (brk pulse, no delivery) instead of delivering them.
module uart_rx_ext #(
    parameter int CLK_HZ    = 25000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    uart_rx_ext_if.master bus
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int M   = CPB / 2;
    localparam int CW  = $clog2(CPB);
    localparam int IW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] SAMP0    = CW'(M - 1);
    localparam logic [CW-1:0] SAMP1    = CW'(M);
    localparam logic [CW-1:0] SAMP2    = CW'(M + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CPB - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    generate
        if (CPB < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
            $error("uart_rx_ext: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_RX_BREAK_EN
        , S_WAIT_HIGH
`endif
    } state_t;

    state_t               state, state_next;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        bit_cnt;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] shreg;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 stop_err;
    logic                 par_bit;
    logic                 done;

    logic maj, sample_now, bit_end, last_stop, par_err;

    // Third sample is the live rx_s, so the bit resolves in the M+1 cycle itself.
    assign maj        = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign sample_now = (bit_cnt == SAMP2);
    assign bit_end    = (bit_cnt == LAST_CNT);
    assign last_stop  = (stop_idx == LAST_STOP);
    assign par_err    = (PARITY == 0) ? 1'b0 :
                        (PARITY == 1) ? ~(^shreg ^ par_bit) : (^shreg ^ par_bit);

`ifdef UART_RX_BREAK_EN
    logic stop0;
    logic brk_hit;
    logic is_break;
    logic first_stop;

    assign first_stop = (stop_idx == 1'b0) ? maj : stop0;
    assign is_break   = (shreg == '0) && ((PARITY == 0) || !par_bit) && !first_stop;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
`ifdef UART_RX_BREAK_EN
        brk_hit    = 1'b0;
`endif
        case (state)
            S_IDLE:   if (!rx_s) state_next = S_START;
            S_START: begin
                if (sample_now && maj) state_next = S_IDLE;
                else if (bit_end)      state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_idx == LAST_IDX)
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_end) state_next = S_STOP;
            // Leave at the final sample point so a back-to-back start bit is not missed.
            S_STOP: begin
                if (sample_now && last_stop) begin
`ifdef UART_RX_BREAK_EN
                    if (is_break) begin
                        brk_hit    = 1'b1;
                        state_next = S_WAIT_HIGH;
                    end else begin
                        done       = 1'b1;
                        state_next = S_IDLE;
                    end
`else
                    done       = 1'b1;
                    state_next = S_IDLE;
`endif
                end
            end
`ifdef UART_RX_BREAK_EN
            S_WAIT_HIGH: if (rx_s) state_next = S_IDLE;
`endif
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            bit_cnt  <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            stop_err <= 1'b0;
            par_bit  <= 1'b0;
`ifdef UART_RX_BREAK_EN
            stop0    <= 1'b1;
`endif
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;

            if (state == S_IDLE || bit_end) bit_cnt <= '0;
            else                            bit_cnt <= bit_cnt + 1'b1;

            if (bit_cnt == SAMP0) s0 <= rx_s;
            if (bit_cnt == SAMP1) s1 <= rx_s;

            case (state)
                S_START: begin
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    stop_err <= 1'b0;
                end
                S_DATA: begin
                    if (sample_now) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (bit_end)    bit_idx <= bit_idx + 1'b1;
                end
                S_PARITY: if (sample_now) par_bit <= maj;
                S_STOP: begin
                    if (sample_now) begin
                        stop_err <= stop_err | ~maj;
`ifdef UART_RX_BREAK_EN
                        if (stop_idx == 1'b0) stop0 <= maj;
`endif
                    end
                    if (bit_end) stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A completing frame always loads; ack in the same cycle only decides whether it counts as overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data       <= '0;
            bus.valid      <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else if (done) begin
            bus.data       <= shreg;
            bus.parity_err <= par_err;
            bus.frame_err  <= stop_err | ~maj;
            bus.valid      <= 1'b1;
            bus.overrun    <= bus.valid & ~bus.ack;
        end else if (bus.valid && bus.ack) begin
            bus.valid      <= 1'b0;
            bus.overrun    <= 1'b0;
        end
    end

`ifdef UART_RX_BREAK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.brk <= 1'b0;
        else     bus.brk <= brk_hit;
    end
`else
    assign bus.brk = 1'b0;
`endif
endmodule
